// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcodes, FSM states and default latencies (MDU_MADD_EN enables MADD family)
package mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    // Opcodes that take the multiplier latency; the MADD family only exists when enabled
    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) ||
                 (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational 64-bit multiply/divide datapath (MDU_MADD_EN adds accumulate forms)
module mdu_core
    import mdu_pkg::*;
(
    input  logic [3:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        div_zero
);

    logic [63:0] ext_sa, ext_sb, ext_ua, ext_ub;
    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] mag_a, mag_b, divisor, q, r, quo, rem;

    assign ext_sa = {{32{srcA[31]}}, srcA};
    assign ext_sb = {{32{srcB[31]}}, srcB};
    assign ext_ua = {32'd0, srcA};
    assign ext_ub = {32'd0, srcB};
    assign prod_s = ext_sa * ext_sb;
    assign prod_u = ext_ua * ext_ub;

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping
    assign div_signed = (mdOp == MD_DIV);
    assign mag_a      = (div_signed && srcA[31]) ? -srcA : srcA;
    assign mag_b      = (div_signed && srcB[31]) ? -srcB : srcB;
    assign divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q          = mag_a / divisor;
    assign r          = mag_a % divisor;
    assign quo        = (div_signed && (srcA[31] ^ srcB[31])) ? -q : q;
    assign rem        = (div_signed && srcA[31]) ? -r : r;
    assign div_zero   = (srcB == 32'd0);

    always_comb begin
        res = 64'd0;
        case (mdOp)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV,
            MD_DIVU:  res = {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD:  res = {hi, lo} + prod_s;
            MD_MADDU: res = {hi, lo} + prod_u;
            MD_MSUB:  res = {hi, lo} - prod_s;
            MD_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:  res = 64'd0;
        endcase
    end

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO registers (MDU_MADD_EN enables MADD family)
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdRes
);

    md_state_t   state;
    logic [3:0]  cnt;
    logic [31:0] temp_hi, temp_lo;
    logic        temp_dz;
    logic [63:0] core_res;
    logic        core_dz;

    mdu_core u_core (
        .mdOp     (mdOp),
        .srcA     (srcA),
        .srcB     (srcB),
        .hi       (hi),
        .lo       (lo),
        .res      (core_res),
        .div_zero (core_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            temp_dz <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mul_op(mdOp)) begin
                            temp_hi <= core_res[63:32];
                            temp_lo <= core_res[31:0];
                            temp_dz <= 1'b0;
                            cnt     <= 4'(MULT_CYCLES);
                            state   <= ST_MUL;
                            busy    <= 1'b1;
                        end else if (is_div_op(mdOp)) begin
                            temp_hi <= core_res[63:32];
                            temp_lo <= core_res[31:0];
                            temp_dz <= core_dz;
                            cnt     <= 4'(DIV_CYCLES);
                            state   <= ST_DIV;
                            busy    <= 1'b1;
                        end else if (mdOp == MD_MTHI) begin
                            hi <= srcA;
                        end else if (mdOp == MD_MTLO) begin
                            lo <= srcA;
                        end
                    end
                end
                default: begin
                    cnt <= cnt - 4'd1;
                    // Divide-by-zero still burns the full latency but leaves HI/LO untouched
                    if (cnt == 4'd1) begin
                        if (!temp_dz) begin
                            hi <= temp_hi;
                            lo <= temp_lo;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        mdRes = 32'd0;
        if (mdOp == MD_MFHI)
            mdRes = hi;
        else if (mdOp == MD_MFLO)
            mdRes = lo;
    end

endmodule
